// File: rtl/cnn_feature_streamer.sv
// -----------------------------------------------------------------------------
// cnn_feature_streamer
//
// Small on-chip feature buffer that replays a window of stored words to the
// CNN datapath. Words are loaded through a plain write port. When playback
// starts, num_of_dat+1 words are read from base_addr onward, and that window
// is repeated num_of_pass+1 times. Addresses wrap modulo DEPTH. The output uses
// a valid/ready handshake. done pulses for one cycle after the consumer has
// accepted the final word.
//
// Optional feature (macro CNN_STREAMER_LAST_EN):
//   When the macro is defined, the port dat_out_last is added. It marks the
//   final word of every pass, which includes the final word of the transfer.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_dat  load port (always active, read-before-write)
//   start              single-cycle playback request (accepted in IDLE only)
//   base_addr          first word address   (latched on accepted start)
//   num_of_dat         words per pass - 1   (latched on accepted start)
//   num_of_pass        passes - 1           (latched on accepted start)
//   dat_out/dat_out_vld/dat_out_rdy  output stream with handshake
//   busy               playback in progress (includes the done cycle)
//   done               one-cycle pulse after the last word is accepted
//   dat_out_last       (CNN_STREAMER_LAST_EN only) last word of a pass
// -----------------------------------------------------------------------------
module cnn_feature_streamer #(
    parameter int WIDTH      = 256,
    parameter int DEPTH      = 8,
    parameter int log2_DEPTH = 3,
    parameter int PASS_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [log2_DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic                  start,
    input  logic [log2_DEPTH-1:0] base_addr,
    input  logic [log2_DEPTH-1:0] num_of_dat,
    input  logic [PASS_W-1:0]     num_of_pass,
    output logic [WIDTH-1:0]      dat_out,
    output logic                  dat_out_vld,
    input  logic                  dat_out_rdy,
    output logic                  busy,
    output logic                  done
`ifdef CNN_STREAMER_LAST_EN
    ,
    output logic                  dat_out_last
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [log2_DEPTH-1:0] base_reg;
    logic [log2_DEPTH-1:0] num_dat_reg;
    logic [PASS_W-1:0]     num_pass_reg;
    logic [log2_DEPTH-1:0] word_cnt_reg;
    logic [PASS_W-1:0]     pass_cnt_reg;
    logic [WIDTH-1:0]      dat_out_reg;
    logic                  vld_reg;
    logic                  done_reg;
    logic                  last_reg;

    logic                  issue;
    logic                  xfer;
    logic                  accept_start;
    logic                  word_wrap;
    logic                  final_issue;
    logic [log2_DEPTH-1:0] rd_addr;

    // Because the sum has log2_DEPTH bits, the read address wraps modulo DEPTH.
    assign rd_addr      = base_reg + word_cnt_reg;
    assign word_wrap    = (word_cnt_reg == num_dat_reg);
    assign final_issue  = issue && word_wrap && (pass_cnt_reg == num_pass_reg);
    assign xfer         = vld_reg && dat_out_rdy;
    assign accept_start = (state_reg == IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)       state_next = RUN;
            RUN:     if (final_issue) state_next = LAST;
            LAST:    if (xfer)        state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // A new word can be issued when the output register is empty or is being
    // drained in this same cycle.
    always_comb begin
        issue = (state_reg == RUN) && (!vld_reg || dat_out_rdy);
        // busy also covers the done cycle, when the FSM has already returned to IDLE.
        busy  = (state_reg != IDLE) || done_reg;
    end

    // ---------------- Load port (no reset on storage) ----------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // ---------------- Playback parameters and counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg     <= '0;
            num_dat_reg  <= '0;
            num_pass_reg <= '0;
            word_cnt_reg <= '0;
            pass_cnt_reg <= '0;
        end else if (accept_start) begin
            base_reg     <= base_addr;
            num_dat_reg  <= num_of_dat;
            num_pass_reg <= num_of_pass;
            word_cnt_reg <= '0;
            pass_cnt_reg <= '0;
        end else if (issue) begin
            if (word_wrap) begin
                word_cnt_reg <= '0;
                if (pass_cnt_reg != num_pass_reg) begin
                    pass_cnt_reg <= pass_cnt_reg + 1'b1;
                end
            end else begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    // ---------------- Output register ----------------
    // This is a registered read. Because the memory write is non-blocking, a
    // read and a write to the same address in one cycle return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_out_reg <= '0;
            vld_reg     <= 1'b0;
            last_reg    <= 1'b0;
        end else if (issue) begin
            dat_out_reg <= mem[rd_addr];
            vld_reg     <= 1'b1;
            last_reg    <= word_wrap;
        end else if (xfer) begin
            vld_reg     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == LAST) && xfer;
        end
    end

    assign dat_out     = dat_out_reg;
    assign dat_out_vld = vld_reg;
    assign done        = done_reg;

`ifdef CNN_STREAMER_LAST_EN
    assign dat_out_last = last_reg;
`else
    // In this build no port exposes the pass marker, so it has no consumer.
    logic unused_last;
    assign unused_last = last_reg;
`endif

endmodule

// File: tb/tb_cnn_feature_streamer.sv
// -----------------------------------------------------------------------------
// tb_cnn_feature_streamer
//
// Directed testbench for cnn_feature_streamer. It preloads mem[i] = 0x10 + i
// and then runs these playback scenarios:
//   - basic playback
//   - address wrap-around
//   - multiple passes
//   - backpressure
//   - start while busy
//   - reset in the middle of a stream, followed by a restart
// Inputs are driven, and outputs sampled, on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cnn_feature_streamer;

    localparam int WIDTH      = 256;
    localparam int DEPTH      = 8;
    localparam int log2_DEPTH = 3;
    localparam int PASS_W     = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  wr_en;
    logic [log2_DEPTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_dat;
    logic                  start;
    logic [log2_DEPTH-1:0] base_addr;
    logic [log2_DEPTH-1:0] num_of_dat;
    logic [PASS_W-1:0]     num_of_pass;
    logic [WIDTH-1:0]      dat_out;
    logic                  dat_out_vld;
    logic                  dat_out_rdy;
    logic                  busy;
    logic                  done;
`ifdef CNN_STREAMER_LAST_EN
    logic                  dat_out_last;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    cnn_feature_streamer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .log2_DEPTH(log2_DEPTH), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .start(start), .base_addr(base_addr), .num_of_dat(num_of_dat),
        .num_of_pass(num_of_pass),
        .dat_out(dat_out), .dat_out_vld(dat_out_vld), .dat_out_rdy(dat_out_rdy),
        .busy(busy), .done(done)
`ifdef CNN_STREAMER_LAST_EN
        , .dat_out_last(dat_out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word k of a stream: mem[(base + k mod (nd+1)) mod 8], where mem[i] = 0x10 + i.
    function automatic logic [WIDTH-1:0] exp_word(input int base, input int nd, input int k);
        return WIDTH'(32'h10 + ((base + (k % (nd + 1))) % DEPTH));
    endfunction

    // Run one playback. rdy is low for stall_len cycles, starting at cycle stall_at.
    // If inject_at is non-zero, a conflicting start is pulsed at that cycle.
    task automatic run_stream(input string name, input int base, input int nd, input int np,
                              input int stall_at, input int stall_len, input int inject_at);
        int k = 0;
        int cyc = 0;
        int last_acc = -10;
        int total = (nd + 1) * (np + 1);
        bit finished = 1'b0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        @(negedge clk);
        start       = 1'b1;
        base_addr   = log2_DEPTH'(base);
        num_of_dat  = log2_DEPTH'(nd);
        num_of_pass = PASS_W'(np);
        dat_out_rdy = 1'b1;
        while (!finished && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check({name, ":vld_c1"}, WIDTH'(dat_out_vld), WIDTH'(1'b0));
                check({name, ":busy_c1"}, WIDTH'(busy), WIDTH'(1'b1));
            end
            if (cyc == 2) check({name, ":vld_c2"}, WIDTH'(dat_out_vld), WIDTH'(1'b1));
            if (pv && !pr) begin
                check({name, ":hold_vld"}, WIDTH'(dat_out_vld), WIDTH'(1'b1));
                check({name, ":hold_dat"}, dat_out, pd);
            end
            if (inject_at != 0 && cyc == inject_at) begin
                start       = 1'b1;
                base_addr   = 3'd5;
                num_of_dat  = 3'd0;
                num_of_pass = 4'd0;
            end
            dat_out_rdy = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (done) begin
                check({name, ":done_lat"}, WIDTH'(cyc), WIDTH'(last_acc + 1));
                check({name, ":busy_done"}, WIDTH'(busy), WIDTH'(1'b1));
                check({name, ":count"}, WIDTH'(k), WIDTH'(total));
                finished = 1'b1;
            end
            if (dat_out_vld && dat_out_rdy && !finished) begin
                if (k >= total) begin
                    check({name, ":extra_word"}, WIDTH'(1'b1), WIDTH'(1'b0));
                end else begin
                    check({name, ":dat"}, dat_out, exp_word(base, nd, k));
`ifdef CNN_STREAMER_LAST_EN
                    check({name, ":last"}, WIDTH'(dat_out_last),
                          WIDTH'((k % (nd + 1)) == nd));
`endif
                end
                $display("[TB] %s word %0d = %0h (cycle %0d)", name, k, dat_out[31:0], cyc);
                last_acc = cyc;
                k++;
            end
            pv = dat_out_vld;
            pr = dat_out_rdy;
            pd = dat_out;
        end
        if (!finished) check({name, ":timeout"}, WIDTH'(1'b0), WIDTH'(1'b1));
        // The done pulse lasts one cycle, and a start seen while busy must not have been queued.
        repeat (3) begin
            @(negedge clk);
            check({name, ":post_done"}, WIDTH'(done), WIDTH'(1'b0));
            check({name, ":post_vld"}, WIDTH'(dat_out_vld), WIDTH'(1'b0));
            check({name, ":post_busy"}, WIDTH'(busy), WIDTH'(1'b0));
        end
    endtask

    initial begin
        int acc;
        int guard;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_dat      = '0;
        start       = 1'b0;
        base_addr   = '0;
        num_of_dat  = '0;
        num_of_pass = '0;
        dat_out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst:dat", dat_out, '0);
        check("rst:vld", WIDTH'(dat_out_vld), WIDTH'(1'b0));
        check("rst:busy", WIDTH'(busy), WIDTH'(1'b0));
        check("rst:done", WIDTH'(done), WIDTH'(1'b0));
`ifdef CNN_STREAMER_LAST_EN
        check("rst:last", WIDTH'(dat_out_last), WIDTH'(1'b0));
`endif
        rst_n = 1'b1;

        // Preload mem[i] = 0x10 + i.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = log2_DEPTH'(i);
            wr_dat  = WIDTH'(32'h10 + i);
        end
        @(negedge clk);
        wr_en = 1'b0;

        run_stream("basic",     0, 3, 0, 0, 0, 0);
        run_stream("wrap",      6, 3, 0, 0, 0, 0);
        run_stream("multipass", 2, 1, 2, 0, 0, 0);
        run_stream("stall",     0, 3, 0, 3, 3, 0);
        run_stream("busystart", 1, 3, 0, 0, 0, 3);

        // Reset in the middle of a stream.
        @(negedge clk);
        start       = 1'b1;
        base_addr   = 3'd0;
        num_of_dat  = 3'd3;
        num_of_pass = 4'd0;
        dat_out_rdy = 1'b1;
        acc   = 0;
        guard = 0;
        while (acc < 2 && guard < 20) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (dat_out_vld && dat_out_rdy) acc++;
        end
        check("rstmid:words_before", WIDTH'(acc), WIDTH'(2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid:dat", dat_out, '0);
        check("rstmid:vld", WIDTH'(dat_out_vld), WIDTH'(1'b0));
        check("rstmid:busy", WIDTH'(busy), WIDTH'(1'b0));
        check("rstmid:done", WIDTH'(done), WIDTH'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstmid:no_done", WIDTH'(done), WIDTH'(1'b0));
            check("rstmid:idle_vld", WIDTH'(dat_out_vld), WIDTH'(1'b0));
        end
        run_stream("restart", 4, 2, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
